pipeline_tx: RTL and testbench

// - Transmit side of the 4-lane pipeline input stream: turns one 16-word packet into 4 beats of 4 words each, qualified by tx_en.
// - The receiver collects the beats and computes its float/double sum.
// - Accepts packets upstream over valid/ready, with one pending-packet buffer so packets go back-to-back.
// - Inserts the idle gap the receiver needs to flag packet completion.

---
 rtl/pipeline_tx.sv | 147 ++++++++++++++
 tb/tb_pipeline_tx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_tx.sv
// Packet-to-beat transmitter: one INPUTS_NU-word packet goes out as INPUTS_NU/PORTS_NU beats, then GAP_CYC idle cycles.
// Optional PIPELINE_TX_STALL_EN adds a tx_stall input that freezes beat issue and the gap counter.
module pipeline_tx #(
    parameter int WORD_W    = 32,
    parameter int PORTS_NU  = 4,
    parameter int INPUTS_NU = 16,
    parameter int GAP_CYC   = 1,
    parameter int CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [INPUTS_NU*WORD_W-1:0] s_data,
`ifdef PIPELINE_TX_STALL_EN
    input  logic                        tx_stall,
`endif
    output logic                        tx_en,
    output logic [PORTS_NU*WORD_W-1:0]  tx_data,
    output logic                        busy,
    output logic [CNT_W-1:0]            pkt_cnt
);

    localparam int BEATS     = INPUTS_NU / PORTS_NU;
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int BEAT_BITS = PORTS_NU * WORD_W;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [3:0]        GAP_LAST  = 4'(GAP_CYC - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]                  state;
    logic [BEAT_W-1:0]           beat_cnt;
    logic [BEAT_W-1:0]           next_beat;
    logic [3:0]                  gap_cnt;
    logic [INPUTS_NU*WORD_W-1:0] active_buf;
    logic [INPUTS_NU*WORD_W-1:0] pend_buf;
    logic                        pend_full;
    logic                        pend_full_nxt;
    logic [BEAT_BITS-1:0]        next_beat_data;
    logic                        stall;
    logic                        xfer;
    logic                        gap_done;
    logic                        take_pend;

`ifdef PIPELINE_TX_STALL_EN
    assign stall = tx_stall;
`else
    assign stall = 1'b0;
`endif

    assign xfer      = s_valid && s_ready;
    assign busy      = (state != IDLE);
    assign next_beat = beat_cnt + 1'b1;
    assign gap_done  = (state == GAP) && !stall && (gap_cnt == GAP_LAST);
    assign take_pend = gap_done && pend_full;

    // Pending slot is freed by the GAP->SEND move and refilled by any handshake outside IDLE.
    assign pend_full_nxt = (pend_full && !take_pend) || (xfer && (state != IDLE));

    always_comb begin
        next_beat_data = active_buf[int'(next_beat)*BEAT_BITS +: BEAT_BITS];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            gap_cnt    <= '0;
            active_buf <= '0;
            pend_buf   <= '0;
            pend_full  <= 1'b0;
            s_ready    <= 1'b0;
            tx_en      <= 1'b0;
            tx_data    <= '0;
            pkt_cnt    <= '0;
        end else begin
            pend_full <= pend_full_nxt;
            s_ready   <= !pend_full_nxt;
            if (xfer && (state != IDLE)) begin
                pend_buf <= s_data;
            end

            // beat_cnt always names the beat most recently put on tx_data.
            case (state)
                IDLE: begin
                    tx_en <= 1'b0;
                    if (xfer) begin
                        active_buf <= s_data;
                        tx_data    <= s_data[0 +: BEAT_BITS];
                        tx_en      <= 1'b1;
                        beat_cnt   <= '0;
                        state      <= SEND;
                        if (BEATS == 1) begin
                            pkt_cnt <= pkt_cnt + 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (stall) begin
                        tx_en <= 1'b0;
                    end else if (beat_cnt == LAST_BEAT) begin
                        tx_en   <= 1'b0;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        tx_en    <= 1'b1;
                        tx_data  <= next_beat_data;
                        beat_cnt <= next_beat;
                        if (next_beat == LAST_BEAT) begin
                            pkt_cnt <= pkt_cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    tx_en <= 1'b0;
                    if (!stall) begin
                        if (gap_cnt == GAP_LAST) begin
                            if (pend_full) begin
                                active_buf <= pend_buf;
                                tx_data    <= pend_buf[0 +: BEAT_BITS];
                                tx_en      <= 1'b1;
                                beat_cnt   <= '0;
                                state      <= SEND;
                                if (BEATS == 1) begin
                                    pkt_cnt <= pkt_cnt + 1'b1;
                                end
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_en <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_tx.sv
// Directed bench for pipeline_tx: reset, single packet, back-to-back packets, mid-packet reset,
// and (with PIPELINE_TX_STALL_EN) a stall in the middle of a packet.
module tb_pipeline_tx;

    localparam int WORD_W    = 32;
    localparam int PORTS_NU  = 4;
    localparam int INPUTS_NU = 16;
    localparam int GAP_CYC   = 2;
    localparam int CNT_W     = 16;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        s_valid;
    logic                        s_ready;
    logic [INPUTS_NU*WORD_W-1:0] s_data;
    logic                        tx_en;
    logic [PORTS_NU*WORD_W-1:0]  tx_data;
    logic                        busy;
    logic [CNT_W-1:0]            pkt_cnt;
`ifdef PIPELINE_TX_STALL_EN
    logic                        tx_stall;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipeline_tx #(
        .WORD_W   (WORD_W),
        .PORTS_NU (PORTS_NU),
        .INPUTS_NU(INPUTS_NU),
        .GAP_CYC  (GAP_CYC),
        .CNT_W    (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
`ifdef PIPELINE_TX_STALL_EN
        .tx_stall(tx_stall),
`endif
        .tx_en   (tx_en),
        .tx_data (tx_data),
        .busy    (busy),
        .pkt_cnt (pkt_cnt)
    );

    // Packet whose word i holds base+i.
    function automatic logic [INPUTS_NU*WORD_W-1:0] mkPkt(input int base);
        logic [INPUTS_NU*WORD_W-1:0] p;
        p = '0;
        for (int i = 0; i < INPUTS_NU; i++) p[i*WORD_W +: WORD_W] = 32'(base + i);
        return p;
    endfunction

    // Expected beat b of packet base: lane k carries word b*PORTS_NU+k.
    function automatic logic [PORTS_NU*WORD_W-1:0] expBeat(input int base, input int b);
        logic [PORTS_NU*WORD_W-1:0] r;
        r = '0;
        for (int k = 0; k < PORTS_NU; k++) r[k*WORD_W +: WORD_W] = 32'(base + b*PORTS_NU + k);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [INPUTS_NU*WORD_W-1:0] d);
        rst     = r;
        s_valid = v;
        s_data  = d;
        @(posedge clk);
        #1;
    endtask

    // Checks beats 1..3 of a packet whose beat 0 is already on the bus.
    task automatic checkRestOfPacket(input int base, input int cnt_after);
        for (int b = 1; b < INPUTS_NU/PORTS_NU; b++) begin
            applyStimulus(1'b1, 1'b0, '0);
            checkOutput($sformatf("beat%0d_en", b), tx_en, 1'b1);
            checkOutput($sformatf("beat%0d_data", b), tx_data, expBeat(base, b));
        end
        checkOutput("pkt_cnt_last", pkt_cnt, cnt_after);
    endtask

    task automatic checkGapThenIdle(input int base);
        for (int g = 0; g < GAP_CYC; g++) begin
            applyStimulus(1'b1, 1'b0, '0);
            checkOutput("gap_en", tx_en, 1'b0);
            checkOutput("gap_busy", busy, 1'b1);
            checkOutput("gap_hold", tx_data, expBeat(base, INPUTS_NU/PORTS_NU - 1));
        end
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("idle_busy", busy, 1'b0);
        checkOutput("idle_ready", s_ready, 1'b1);
    endtask

    initial begin
        rst     = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
`ifdef PIPELINE_TX_STALL_EN
        tx_stall = 1'b0;
`endif

        // Reset held for 3 cycles with s_valid asserted.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, mkPkt(1));
        checkOutput("rst_en", tx_en, 1'b0);
        checkOutput("rst_data", tx_data, '0);
        checkOutput("rst_ready", s_ready, 1'b0);
        checkOutput("rst_cnt", pkt_cnt, '0);
        checkOutput("rst_busy", busy, 1'b0);
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("rel_ready", s_ready, 1'b1);
        checkOutput("rel_en", tx_en, 1'b0);

        // Single packet, words 1..16.
        applyStimulus(1'b1, 1'b1, mkPkt(1));
        checkOutput("p1_beat0_en", tx_en, 1'b1);
        checkOutput("p1_beat0_data", tx_data, expBeat(1, 0));
        checkOutput("p1_busy", busy, 1'b1);
        checkRestOfPacket(1, 1);
        checkGapThenIdle(1);

        // Two packets back-to-back; the second waits in the pending slot.
        applyStimulus(1'b1, 1'b1, mkPkt(32'h100));
        checkOutput("bb_beat0", tx_data, expBeat(32'h100, 0));
        checkOutput("bb_ready1", s_ready, 1'b1);
        applyStimulus(1'b1, 1'b1, mkPkt(32'h200));
        checkOutput("bb_beat1", tx_data, expBeat(32'h100, 1));
        checkOutput("bb_ready_full", s_ready, 1'b0);
        for (int b = 2; b < 4; b++) begin
            applyStimulus(1'b1, 1'b0, '0);
            checkOutput("bb_beat_en", tx_en, 1'b1);
            checkOutput("bb_beat_data", tx_data, expBeat(32'h100, b));
        end
        checkOutput("bb_cnt2", pkt_cnt, 2);
        for (int g = 0; g < GAP_CYC; g++) begin
            applyStimulus(1'b1, 1'b0, '0);
            checkOutput("bb_gap_en", tx_en, 1'b0);
            checkOutput("bb_gap_ready", s_ready, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("bb2_beat0_en", tx_en, 1'b1);
        checkOutput("bb2_beat0_data", tx_data, expBeat(32'h200, 0));
        checkOutput("bb2_ready", s_ready, 1'b1);
        checkRestOfPacket(32'h200, 3);
        checkGapThenIdle(32'h200);

        // Reset after beat 1 with a packet pending: everything is dropped.
        applyStimulus(1'b1, 1'b1, mkPkt(32'h300));
        checkOutput("mr_beat0", tx_data, expBeat(32'h300, 0));
        applyStimulus(1'b1, 1'b1, mkPkt(32'h400));
        checkOutput("mr_beat1", tx_data, expBeat(32'h300, 1));
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("mr_en", tx_en, 1'b0);
        checkOutput("mr_cnt", pkt_cnt, '0);
        checkOutput("mr_busy", busy, 1'b0);
        checkOutput("mr_ready", s_ready, 1'b0);
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("mr_rel_ready", s_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, '0);
            checkOutput("mr_quiet", tx_en, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, mkPkt(32'h500));
        checkOutput("mr_new_en", tx_en, 1'b1);
        checkOutput("mr_new_beat0", tx_data, expBeat(32'h500, 0));
        checkRestOfPacket(32'h500, 1);
        checkGapThenIdle(32'h500);

`ifdef PIPELINE_TX_STALL_EN
        // Stall for 3 cycles while beat 2 is due.
        applyStimulus(1'b1, 1'b1, mkPkt(32'h600));
        checkOutput("st_beat0", tx_data, expBeat(32'h600, 0));
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("st_beat1", tx_data, expBeat(32'h600, 1));
        tx_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, '0);
            checkOutput("st_en", tx_en, 1'b0);
            checkOutput("st_hold", tx_data, expBeat(32'h600, 1));
            checkOutput("st_busy", busy, 1'b1);
        end
        tx_stall = 1'b0;
        for (int b = 2; b < 4; b++) begin
            applyStimulus(1'b1, 1'b0, '0);
            checkOutput("st_beat_en", tx_en, 1'b1);
            checkOutput("st_beat_data", tx_data, expBeat(32'h600, b));
        end
        checkOutput("st_cnt", pkt_cnt, 2);
        checkGapThenIdle(32'h600);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
